// File: rtl/mxint_dot_product_arbiter_pkg.sv
// mxint_dot_product_arbiter_pkg: arbiter state encoding and round-robin pick helper
package mxint_dot_product_arbiter_pkg;
  localparam int MAX_REQ = 32;
  typedef enum logic {IDLE, ISSUE} state_t;
  function automatic logic [4:0] rr_pick(input logic [MAX_REQ-1:0] v, input logic [4:0] ptr, input logic [5:0] n);
    logic [5:0] idx;
    logic found;
    rr_pick = ptr;
    found = 1'b0;
    for (int i = 0; i < MAX_REQ; i++) begin
      idx = {1'b0, ptr} + 6'(i);
      idx = (idx >= n) ? idx - n : idx;
      if (6'(i) < n && !found && v[idx[4:0]]) begin
        rr_pick = idx[4:0];
        found = 1'b1;
      end
    end
  endfunction
endpackage

// File: rtl/mxint_dot_product_arbiter_fifo.sv
// mxint_dot_product_arbiter_fifo: circular-buffer fifo holding the issuing requester of each in-flight op
module mxint_dot_product_arbiter_fifo #(
  parameter int DATA_WIDTH = 2,
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic push, pop;
  always_comb begin
    in_ready = cnt_q != CW'(DEPTH);
    out_valid = cnt_q != '0;
    out_data = mem_q[rd_q];
    push = in_valid & in_ready;
    pop = out_valid & out_ready;
    wr_d = push ? ((wr_q == AW'(DEPTH - 1)) ? '0 : wr_q + 1'b1) : wr_q;
    rd_d = pop ? ((rd_q == AW'(DEPTH - 1)) ? '0 : rd_q + 1'b1) : rd_q;
    cnt_d = cnt_q + CW'(push) - CW'(pop);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= in_data;
  end
endmodule

// File: rtl/mxint_dot_product_arbiter.sv
// mxint_dot_product_arbiter: round-robin sharing of one mxint dot product, results routed back by tag
module mxint_dot_product_arbiter
  import mxint_dot_product_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_IN_0_PRECISION_0 = 8,
  parameter int DATA_IN_0_PRECISION_1 = 8,
  parameter int WEIGHT_PRECISION_0 = 8,
  parameter int WEIGHT_PRECISION_1 = 8,
  parameter int BLOCK_SIZE = 6,
  parameter int DATA_OUT_0_PRECISION_0 = DATA_IN_0_PRECISION_0 + WEIGHT_PRECISION_0 + $clog2(BLOCK_SIZE),
  parameter int DATA_OUT_0_PRECISION_1 = ((DATA_IN_0_PRECISION_1 > WEIGHT_PRECISION_1) ? DATA_IN_0_PRECISION_1 : WEIGHT_PRECISION_1) + 1,
  parameter int MAX_OUTSTANDING = 4,
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic clk,
  input  logic rst,
  input  logic [NUM_REQ-1:0][BLOCK_SIZE-1:0][DATA_IN_0_PRECISION_0-1:0] req_mdata_in_0,
  input  logic [NUM_REQ-1:0][DATA_IN_0_PRECISION_1-1:0]                 req_edata_in_0,
  input  logic [NUM_REQ-1:0][BLOCK_SIZE-1:0][WEIGHT_PRECISION_0-1:0]    req_mweight,
  input  logic [NUM_REQ-1:0][WEIGHT_PRECISION_1-1:0]                    req_eweight,
  input  logic [NUM_REQ-1:0] req_valid,
  output logic [NUM_REQ-1:0] req_ready,
  output logic [BLOCK_SIZE-1:0][DATA_IN_0_PRECISION_0-1:0] dp_mdata_in_0,
  output logic [DATA_IN_0_PRECISION_1-1:0]                 dp_edata_in_0,
  output logic dp_data_in_0_valid,
  input  logic dp_data_in_0_ready,
  output logic [BLOCK_SIZE-1:0][WEIGHT_PRECISION_0-1:0] dp_mweight,
  output logic [WEIGHT_PRECISION_1-1:0]                 dp_eweight,
  output logic dp_weight_valid,
  input  logic dp_weight_ready,
  input  logic [DATA_OUT_0_PRECISION_0-1:0] dp_mdata_out_0,
  input  logic [DATA_OUT_0_PRECISION_1-1:0] dp_edata_out_0,
  input  logic dp_data_out_0_valid,
  output logic dp_data_out_0_ready,
  output logic [DATA_OUT_0_PRECISION_0-1:0] resp_mdata_out_0,
  output logic [DATA_OUT_0_PRECISION_1-1:0] resp_edata_out_0,
  output logic [ID_W-1:0] resp_id,
  output logic [NUM_REQ-1:0] resp_valid,
  input  logic [NUM_REQ-1:0] resp_ready,
  output logic err_unexpected_result
);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  state_t state_q, state_d;
  logic [ID_W-1:0] grant_id_q, grant_id_d, rr_ptr_q, rr_ptr_d, head;
  logic data_done_q, data_done_d, weight_done_q, weight_done_d, err_q, err_d;
  logic [CNT_W-1:0] outstanding_q, outstanding_d;
  logic issue, d_done, w_done, complete, tag_valid, tag_ready, pop;
  assign dp_mdata_in_0 = req_mdata_in_0[grant_id_q];
  assign dp_edata_in_0 = req_edata_in_0[grant_id_q];
  assign dp_mweight = req_mweight[grant_id_q];
  assign dp_eweight = req_eweight[grant_id_q];
  assign resp_mdata_out_0 = dp_mdata_out_0;
  assign resp_edata_out_0 = dp_edata_out_0;
  assign err_unexpected_result = err_q;
  mxint_dot_product_arbiter_fifo #(.DATA_WIDTH(ID_W), .DEPTH(MAX_OUTSTANDING)) u_tag_fifo (
    .clk(clk), .rst(rst),
    .in_data(grant_id_q), .in_valid(complete), .in_ready(tag_ready),
    .out_data(head), .out_valid(tag_valid), .out_ready(pop)
  );
  always_comb begin
    state_d = state_q;
    grant_id_d = grant_id_q;
    rr_ptr_d = rr_ptr_q;
    data_done_d = data_done_q;
    weight_done_d = weight_done_q;
    issue = state_q == ISSUE;
    dp_data_in_0_valid = issue & ~data_done_q;
    dp_weight_valid = issue & ~weight_done_q;
    d_done = data_done_q | (dp_data_in_0_valid & dp_data_in_0_ready);
    w_done = weight_done_q | (dp_weight_valid & dp_weight_ready);
    complete = issue & d_done & w_done & tag_ready;
    req_ready = complete ? NUM_REQ'(1) << grant_id_q : '0;
    resp_id = tag_valid ? head : '0;
    resp_valid = (tag_valid & dp_data_out_0_valid) ? NUM_REQ'(1) << head : '0;
    dp_data_out_0_ready = tag_valid & resp_ready[head];
    pop = dp_data_out_0_ready & dp_data_out_0_valid;
    err_d = err_q | (dp_data_out_0_valid & ~tag_valid);
    outstanding_d = outstanding_q + CNT_W'(complete) - CNT_W'(pop);
    if (state_q == IDLE && |req_valid && outstanding_q < CNT_W'(MAX_OUTSTANDING)) begin
      state_d = ISSUE;
      grant_id_d = ID_W'(rr_pick(MAX_REQ'(req_valid), 5'(rr_ptr_q), 6'(NUM_REQ)));
    end else if (issue) begin
      data_done_d = complete ? 1'b0 : d_done;
      weight_done_d = complete ? 1'b0 : w_done;
      state_d = complete ? IDLE : ISSUE;
      rr_ptr_d = complete ? ((grant_id_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_id_q + 1'b1) : rr_ptr_q;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_id_q <= '0;
      rr_ptr_q <= '0;
      data_done_q <= 1'b0;
      weight_done_q <= 1'b0;
      outstanding_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_id_q <= grant_id_d;
      rr_ptr_q <= rr_ptr_d;
      data_done_q <= data_done_d;
      weight_done_q <= weight_done_d;
      outstanding_q <= outstanding_d;
      err_q <= err_d;
    end
  end
endmodule

// File: tb/tb_mxint_dot_product_arbiter.sv
// tb_mxint_dot_product_arbiter: directed checks of grant order, tag routing, back-pressure, error and reset
module tb_mxint_dot_product_arbiter;
  localparam int NR = 4;
  localparam int BS = 6;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NR-1:0][BS-1:0][7:0] req_mdata_in_0, req_mweight;
  logic [NR-1:0][7:0] req_edata_in_0, req_eweight;
  logic [NR-1:0] req_valid, req_ready, resp_valid, resp_ready;
  logic [BS-1:0][7:0] dp_mdata_in_0, dp_mweight;
  logic [7:0] dp_edata_in_0, dp_eweight;
  logic dp_data_in_0_valid, dp_data_in_0_ready, dp_weight_valid, dp_weight_ready;
  logic [18:0] dp_mdata_out_0, resp_mdata_out_0;
  logic [8:0] dp_edata_out_0, resp_edata_out_0;
  logic dp_data_out_0_valid, dp_data_out_0_ready;
  logic [1:0] resp_id;
  logic err_unexpected_result;
  int n_chk = 0;
  int n_fail = 0;
  int g_q[$];
  int r_q[$];
  int exp_g[4] = '{0, 1, 2, 3};
  int exp_r[4] = '{1, 2, 3, 0};
  mxint_dot_product_arbiter dut (
    .clk(clk), .rst(rst),
    .req_mdata_in_0(req_mdata_in_0), .req_edata_in_0(req_edata_in_0),
    .req_mweight(req_mweight), .req_eweight(req_eweight),
    .req_valid(req_valid), .req_ready(req_ready),
    .dp_mdata_in_0(dp_mdata_in_0), .dp_edata_in_0(dp_edata_in_0),
    .dp_data_in_0_valid(dp_data_in_0_valid), .dp_data_in_0_ready(dp_data_in_0_ready),
    .dp_mweight(dp_mweight), .dp_eweight(dp_eweight),
    .dp_weight_valid(dp_weight_valid), .dp_weight_ready(dp_weight_ready),
    .dp_mdata_out_0(dp_mdata_out_0), .dp_edata_out_0(dp_edata_out_0),
    .dp_data_out_0_valid(dp_data_out_0_valid), .dp_data_out_0_ready(dp_data_out_0_ready),
    .resp_mdata_out_0(resp_mdata_out_0), .resp_edata_out_0(resp_edata_out_0),
    .resp_id(resp_id), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .err_unexpected_result(err_unexpected_result)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check_quiet(input string tag);
    check({tag, "_req_ready"}, 32'(req_ready), 0);
    check({tag, "_dvalid"}, 32'(dp_data_in_0_valid), 0);
    check({tag, "_wvalid"}, 32'(dp_weight_valid), 0);
    check({tag, "_resp_valid"}, 32'(resp_valid), 0);
    check({tag, "_out_ready"}, 32'(dp_data_out_0_ready), 0);
    check({tag, "_err"}, 32'(err_unexpected_result), 0);
  endtask
  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    dp_data_out_0_valid = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
  endtask
  task automatic collect(input int cycles, input bit pop);
    for (int c = 0; c < cycles; c++) begin
      tick();
      dp_data_out_0_valid = 1'b0;
      #1;
      check("rr_onehot", 32'($onehot0(req_ready)), 1);
      if (req_ready != '0) begin
        for (int k = 0; k < NR; k++) if (req_ready[k]) g_q.push_back(k);
        if (pop) begin
          dp_data_out_0_valid = 1'b1;
          #1;
          check("pop_ready", 32'(dp_data_out_0_ready), 1);
          r_q.push_back(int'(resp_id));
        end
      end
    end
  endtask
  initial begin
    for (int i = 0; i < NR; i++) begin
      for (int j = 0; j < BS; j++) begin
        req_mdata_in_0[i][j] = 8'(16 * i + j);
        req_mweight[i][j] = 8'(i * j);
      end
      req_edata_in_0[i] = 8'(i + 1);
      req_eweight[i] = 8'(8'h80 + i);
    end
    req_valid = '0;
    resp_ready = '0;
    dp_data_in_0_ready = 1'b0;
    dp_weight_ready = 1'b0;
    dp_mdata_out_0 = '0;
    dp_edata_out_0 = '0;
    dp_data_out_0_valid = 1'b0;
    tick();
    check_quiet("reset");
    do_reset();
    req_valid = 4'b0100;
    dp_data_in_0_ready = 1'b1;
    dp_weight_ready = 1'b1;
    #1;
    check("t1_idle_ready", 32'(req_ready), 0);
    tick();
    check("t1_req_ready", 32'(req_ready), 32'h4);
    check("t1_edata", 32'(dp_edata_in_0), 3);
    check("t1_mdata1", 32'(dp_mdata_in_0[1]), 33);
    check("t1_eweight", 32'(dp_eweight), 32'h82);
    check("t1_mweight3", 32'(dp_mweight[3]), 6);
    tick();
    req_valid = '0;
    #1;
    check("t1_ready_pulse", 32'(req_ready), 0);
    dp_data_out_0_valid = 1'b1;
    dp_mdata_out_0 = 19'h123;
    dp_edata_out_0 = 9'h45;
    resp_ready = 4'b0100;
    #1;
    check("t1_resp_valid", 32'(resp_valid), 32'h4);
    check("t1_resp_id", 32'(resp_id), 2);
    check("t1_out_ready", 32'(dp_data_out_0_ready), 1);
    check("t1_resp_m", 32'(resp_mdata_out_0), 32'h123);
    check("t1_resp_e", 32'(resp_edata_out_0), 32'h45);
    tick();
    dp_data_out_0_valid = 1'b0;
    #1;
    check("t1_resp_done", 32'(resp_valid), 0);
    check("t1_no_err", 32'(err_unexpected_result), 0);
    do_reset();
    resp_ready = 4'hF;
    req_valid = 4'hF;
    g_q.delete();
    r_q.delete();
    collect(12, 1'b0);
    check("t4_issue_cnt", 32'(g_q.size()), 4);
    for (int k = 0; k < 4; k++) check("t2_grant", 32'(g_q[k]), 32'(exp_g[k]));
    dp_data_out_0_valid = 1'b1;
    dp_mdata_out_0 = 19'h100;
    #1;
    check("t2_head0_id", 32'(resp_id), 0);
    check("t2_head0_valid", 32'(resp_valid), 1);
    g_q.delete();
    r_q.delete();
    collect(8, 1'b1);
    check("t4_pp_grants", 32'(g_q.size()), 4);
    check("t4_pp_pops", 32'(r_q.size()), 4);
    for (int k = 0; k < 4; k++) begin
      check("t4_pp_grant", 32'(g_q[k]), 32'(exp_g[k]));
      check("t4_pp_head", 32'(r_q[k]), 32'(exp_r[k]));
    end
    g_q.delete();
    collect(8, 1'b0);
    check("t4_refill_cnt", 32'(g_q.size()), 1);
    check("t4_refill_id", 32'(g_q[0]), 0);
    req_valid = '0;
    resp_ready = 4'b1101;
    dp_data_out_0_valid = 1'b1;
    dp_mdata_out_0 = 19'h7;
    for (int c = 0; c < 5; c++) begin
      #1;
      check("t5_hold_ready", 32'(dp_data_out_0_ready), 0);
      check("t5_hold_valid", 32'(resp_valid), 32'h2);
      check("t5_hold_id", 32'(resp_id), 1);
      tick();
    end
    resp_ready = 4'hF;
    for (int k = 0; k < 4; k++) begin
      dp_mdata_out_0 = 19'(200 + k);
      #1;
      check("t2_drain_id", 32'(resp_id), 32'(exp_r[k]));
      check("t2_drain_valid", 32'(resp_valid), 32'(1) << exp_r[k]);
      check("t2_drain_m", 32'(resp_mdata_out_0), 32'(200 + k));
      tick();
    end
    dp_data_out_0_valid = 1'b0;
    #1;
    check("t2_empty_ready", 32'(dp_data_out_0_ready), 0);
    check("t2_no_err", 32'(err_unexpected_result), 0);
    do_reset();
    req_valid = 4'b0001;
    dp_data_in_0_ready = 1'b1;
    dp_weight_ready = 1'b0;
    tick();
    check("t3_dvalid0", 32'(dp_data_in_0_valid), 1);
    check("t3_wvalid0", 32'(dp_weight_valid), 1);
    check("t3_ready0", 32'(req_ready), 0);
    for (int c = 0; c < 3; c++) begin
      tick();
      check("t3_dvalid_drop", 32'(dp_data_in_0_valid), 0);
      check("t3_wvalid_hold", 32'(dp_weight_valid), 1);
      check("t3_ready_wait", 32'(req_ready), 0);
    end
    dp_weight_ready = 1'b1;
    #1;
    check("t3_ready_pulse", 32'(req_ready), 1);
    tick();
    req_valid = '0;
    dp_data_out_0_valid = 1'b1;
    #1;
    check("t3_ready_clear", 32'(req_ready), 0);
    check("t3_resp_valid", 32'(resp_valid), 1);
    check("t3_resp_id", 32'(resp_id), 0);
    tick();
    check("t6_empty_valid", 32'(resp_valid), 0);
    check("t6_empty_ready", 32'(dp_data_out_0_ready), 0);
    check("t6_err_pre", 32'(err_unexpected_result), 0);
    tick();
    check("t6_err_set", 32'(err_unexpected_result), 1);
    dp_data_out_0_valid = 1'b0;
    repeat (2) tick();
    check("t6_err_sticky", 32'(err_unexpected_result), 1);
    req_valid = 4'b0100;
    dp_weight_ready = 1'b1;
    repeat (2) tick();
    dp_weight_ready = 1'b0;
    tick();
    dp_data_out_0_valid = 1'b1;
    #1;
    check("t6_issue_dvalid", 32'(dp_data_in_0_valid), 1);
    check("t6_pre_resp", 32'(resp_valid), 32'h4);
    rst = 1'b1;
    #1;
    check_quiet("t6_async_rst");
    check("t6_async_id", 32'(resp_id), 0);
    tick();
    do_reset();
    dp_data_out_0_valid = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
